data_bus_ctrl: RTL
==================

// Module: data_bus_ctrl
// PURPOSE
//  Sequences every CPU load/store onto the shared data bus. Decodes the address to one target
//  (data RAM, GPIO0, UART, I2C) and drives a one-hot enable. Waits for the target's ready,
//  with a timeout. Returns registered read data to the CPU with a single-cycle ack/err.
//  Sits between the CPU load/store unit and the peripheral set.
// PARAMETERS
//  RAM_BASE     32'h0000_0000  data RAM region base
//  RAM_MASK     32'hFFFF_0000  region hit when (addr & MASK) == BASE
//  GPIO0_BASE   32'h1000_0000  GPIO0 region base
//  UART_BASE    32'h2000_0000  UART region base
//  I2C_BASE     32'h3000_0000  I2C region base
//  PERIPH_MASK  32'hFFFF_FF00  mask used for the GPIO0, UART and I2C regions
//  TIMEOUT      16             max ACCESS cycles before error; legal range 2..255
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous active-high reset
//  cpu_req       in   1   access request; sampled only in IDLE
//  cpu_we        in   1   1 = store, 0 = load
//  cpu_addr      in   32  byte address
//  cpu_wdata     in   32  store data
//  cpu_ack       out  1   1-cycle pulse: access complete
//  cpu_err       out  1   valid with cpu_ack: unmapped address or timeout
//  cpu_rdata     out  32  load data, valid with cpu_ack
//  dmem_enable   out  1   RAM select (one-hot group)
//  gpio0_enable  out  1   GPIO0 select (one-hot group)
//  uart_enable   out  1   UART select (one-hot group)
//  i2c_enable    out  1   I2C select (one-hot group)
//  bus_we        out  1   latched cpu_we
//  bus_addr      out  32  latched cpu_addr
//  bus_wdata     out  32  latched cpu_wdata
//  ram_data      in   32  RAM read data
//  dmem_ready    in   1   RAM done this cycle
//  gpio0_data    in   8   GPIO0 read data; zero-extended to 32 bits
//  uart_data     in   32  UART read data
//  uart_ready    in   1   UART done this cycle
//  i2c_data      in   32  I2C read data
//  i2c_ready     in   1   I2C done this cycle
// BEHAVIOUR
//  Reset
//   - All outputs are 0 and state = IDLE.
//   - Reset asserted mid-access: enables drop at the next edge; the aborted access gets no ack.
//  State machine: IDLE -> ACCESS -> RESP -> IDLE
//  IDLE
//   - On cpu_req: latch we/addr/wdata into bus_*, decode, clear the cycle counter.
//   - Decode priority on overlapping regions: RAM > GPIO0 > UART > I2C.
//   - No region hit: go straight to RESP with err = 1, rdata = 0. No enable is ever asserted.
//   - Otherwise go to ACCESS.
//  ACCESS
//   - Exactly one enable is high, held for the whole state. bus_* are stable.
//   - GPIO0 is implicitly ready in its first ACCESS cycle.
//   - When the selected ready = 1: capture read data (loads; stores capture 0), err = 0, go to RESP.
//   - Else counter++. If counter == TIMEOUT-1 with no ready: go to RESP with err = 1, rdata = 0.
//   - Ready and timeout in the same cycle: ready wins (err = 0).
//  RESP
//   - Enables low. cpu_ack = 1 for exactly one cycle; cpu_err and cpu_rdata are valid.
//   - Next state is IDLE.
//  cpu_rdata
//   - Registered; holds its value after ack until the next RESP.
//  Latency
//   - Counted from the edge that samples cpu_req: ack at +2 for GPIO0; +2+N for a target ready after N wait cycles.
//   - Unmapped address: ack at +1.
//  Request handling
//   - cpu_req is ignored in ACCESS and RESP. The CPU may drop it after acceptance.
//   - A req held high is re-accepted in the IDLE cycle after RESP (back-to-back accesses).
//   - Ready inputs seen outside ACCESS, or for a non-selected target, are ignored.
// TESTING
//  - Load 0x1000_0004, gpio0_data = 8'hA5 -> gpio0_enable for 1 cycle; ack at +2, err = 0, rdata = 32'h0000_00A5.
//  - Store 0x0000_0010, wdata = 32'hDEAD_BEEF, dmem_ready after 3 waits -> dmem_enable for 4 cycles,
//    bus_wdata = 32'hDEAD_BEEF, ack at +5, rdata = 0.
//  - Load 0x5000_0000 (unmapped) -> no enable ever asserted; ack at +1, err = 1, rdata = 0.
//  - Load 0x2000_0000, uart_ready never asserted -> uart_enable for 16 cycles, then ack with err = 1.
//    Separately: uart_ready on cycle 16 -> err = 0.
//  - cpu_req held high, two RAM loads, dmem_ready immediate -> acks 3 cycles apart, each with the correct ram_data.
//  - rst asserted during a UART ACCESS -> next cycle all enables are 0, no ack; a subsequent request is served normally.

Source files
------------

// File: rtl/data_bus_ctrl.sv
// CPU load/store sequencer for the shared data bus: decodes the target, drives a one-hot
// enable, waits for ready (bounded by TIMEOUT) and returns a one-cycle ack with registered data.
module data_bus_ctrl #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] RAM_MASK    = 32'hFFFF_0000,
  parameter logic [31:0] GPIO0_BASE  = 32'h1000_0000,
  parameter logic [31:0] UART_BASE   = 32'h2000_0000,
  parameter logic [31:0] I2C_BASE    = 32'h3000_0000,
  parameter logic [31:0] PERIPH_MASK = 32'hFFFF_FF00,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        dmem_enable,
  output logic        gpio0_enable,
  output logic        uart_enable,
  output logic        i2c_enable,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] ram_data,
  input  logic        dmem_ready,
  input  logic [7:0]  gpio0_data,
  input  logic [31:0] uart_data,
  input  logic        uart_ready,
  input  logic [31:0] i2c_data,
  input  logic        i2c_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Region index order doubles as decode priority: 0 = RAM (highest) .. 3 = I2C.
  localparam logic [31:0] REGION_BASE [4] = '{RAM_BASE, GPIO0_BASE, UART_BASE, I2C_BASE};
  localparam logic [31:0] REGION_MASK [4] = '{RAM_MASK, PERIPH_MASK, PERIPH_MASK, PERIPH_MASK};
  localparam logic [7:0]  LAST_CYCLE      = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  sel_reg, sel_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;
  logic [31:0] rdata_reg, rdata_next;

  logic [3:0]  hit;
  logic [3:0]  decode;
  logic        ready_sel;
  logic [31:0] rdata_mux;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_region
      assign hit[gi] = (cpu_addr & REGION_MASK[gi]) == REGION_BASE[gi];
    end
  endgenerate

  // Isolate the lowest set hit bit, giving the highest-priority region as one-hot.
  assign decode = hit & (~hit + 4'd1);

  // GPIO0 has no ready line; it completes in its first ACCESS cycle.
  assign ready_sel = (sel_reg[0] & dmem_ready)
                   | (sel_reg[1] & (cnt_reg == 8'd0))
                   | (sel_reg[2] & uart_ready)
                   | (sel_reg[3] & i2c_ready);

  always_comb begin
    rdata_mux = 32'd0;
    if (sel_reg[0])      rdata_mux = ram_data;
    else if (sel_reg[1]) rdata_mux = {24'd0, gpio0_data};
    else if (sel_reg[2]) rdata_mux = uart_data;
    else if (sel_reg[3]) rdata_mux = i2c_data;
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          we_next    = cpu_we;
          addr_next  = cpu_addr;
          wdata_next = cpu_wdata;
          cnt_next   = 8'd0;
          if (hit == 4'd0) begin
            state_next = RESP;
            ack_next   = 1'b1;
            err_next   = 1'b1;
            rdata_next = 32'd0;
          end else begin
            state_next = ACCESS;
            sel_next   = decode;
          end
        end
      end
      ACCESS: begin
        // Ready is checked before the timeout so a last-cycle ready still succeeds.
        if (ready_sel) begin
          state_next = RESP;
          sel_next   = 4'd0;
          ack_next   = 1'b1;
          rdata_next = we_reg ? 32'd0 : rdata_mux;
        end else if (cnt_reg == LAST_CYCLE) begin
          state_next = RESP;
          sel_next   = 4'd0;
          ack_next   = 1'b1;
          err_next   = 1'b1;
          rdata_next = 32'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        sel_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 4'd0;
      cnt_reg   <= 8'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
    end
  end

  assign cpu_ack      = ack_reg;
  assign cpu_err      = err_reg;
  assign cpu_rdata    = rdata_reg;
  assign dmem_enable  = sel_reg[0];
  assign gpio0_enable = sel_reg[1];
  assign uart_enable  = sel_reg[2];
  assign i2c_enable   = sel_reg[3];
  assign bus_we       = we_reg;
  assign bus_addr     = addr_reg;
  assign bus_wdata    = wdata_reg;

endmodule
